// File: rtl/text_writer_if.sv
// Byte-stream handshake between a character source (CPU/UART) and the text writer.
// The source holds in_data/in_attr stable until a cycle with in_valid && in_ready.
interface text_writer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] in_attr;

    modport master (output in_valid, output in_data, output in_attr, input  in_ready);
    modport slave  (input  in_valid, input  in_data, input  in_attr, output in_ready);
endinterface

// File: rtl/text_writer.sv
// Text-mode writer: consumes character/control bytes, tracks the cursor and
// writes {attr, char} words into the character-cell RAM, including clears.
module text_writer #(
    parameter int          COLS       = 80,
    parameter int          ROWS       = 30,
    parameter int          ADDR_W     = 12,
    parameter logic [7:0]  ATTR_BLANK = 8'h07
) (
    input  logic              clk_pix,
    input  logic              rst,
    text_writer_if.slave      src,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic [6:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              busy
);

    typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_LINE} state_t;

    localparam int                CW       = ADDR_W + 1;
    localparam logic [CW-1:0]     CELLS    = CW'(COLS * ROWS);
    localparam logic [CW-1:0]     LINE     = CW'(COLS);
    localparam logic [15:0]       BLANK    = {ATTR_BLANK, 8'h20};
    localparam logic [6:0]        LAST_COL = 7'(COLS - 1);
    localparam logic [4:0]        LAST_ROW = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(COLS);

    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_FF  = 8'h0C;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_DEL = 8'h7F;

    state_t              state_reg, state_next;
    logic                live_reg;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [6:0]          col_reg, col_next;
    logic [4:0]          row_reg, row_next;
    logic [ADDR_W-1:0]   row_base_reg, row_base_next;
    logic                wr_en_reg, wr_en_next;
    logic [ADDR_W-1:0]   wr_addr_reg, wr_addr_next;
    logic [15:0]         wr_data_reg, wr_data_next;

    logic                accept;
    logic                is_print;
    logic [4:0]          adv_row;
    logic [ADDR_W-1:0]   adv_base;
    logic [ADDR_W-1:0]   cursor_addr;

    // live_reg keeps busy/in_ready low while rst is held, even though the
    // state register already points at CLEAR_ALL.
    assign src.in_ready = live_reg && (state_reg == IDLE);
    assign busy         = live_reg && (state_reg != IDLE);
    assign accept       = src.in_valid && src.in_ready;
    assign is_print     = (src.in_data >= 8'h20) && (src.in_data != CH_DEL);

    // Row advance wraps to the top of the screen instead of scrolling.
    assign adv_row     = (row_reg == LAST_ROW) ? 5'd0 : row_reg + 5'd1;
    assign adv_base    = (row_reg == LAST_ROW) ? '0 : row_base_reg + ROW_STEP;
    assign cursor_addr = row_base_reg + ADDR_W'(col_reg);

    assign wr_en      = wr_en_reg;
    assign wr_addr    = wr_addr_reg;
    assign wr_data    = wr_data_reg;
    assign cursor_col = col_reg;
    assign cursor_row = row_reg;

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            state_reg    <= CLEAR_ALL;
            live_reg     <= 1'b0;
            cnt_reg      <= '0;
            col_reg      <= '0;
            row_reg      <= '0;
            row_base_reg <= '0;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            live_reg     <= 1'b1;
            cnt_reg      <= cnt_next;
            col_reg      <= col_next;
            row_reg      <= row_next;
            row_base_reg <= row_base_next;
            wr_en_reg    <= wr_en_next;
            wr_addr_reg  <= wr_addr_next;
            wr_data_reg  <= wr_data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        col_next      = col_reg;
        row_next      = row_reg;
        row_base_next = row_base_reg;
        wr_en_next    = 1'b0;
        wr_addr_next  = wr_addr_reg;
        wr_data_next  = wr_data_reg;

        case (state_reg)
            CLEAR_ALL: begin
                if (live_reg) begin
                    if (cnt_reg < CELLS) begin
                        wr_en_next   = 1'b1;
                        wr_addr_next = cnt_reg[ADDR_W-1:0];
                        wr_data_next = BLANK;
                        cnt_next     = cnt_reg + 1'b1;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end
            end

            CLEAR_LINE: begin
                if (cnt_reg < LINE) begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = row_base_reg + ADDR_W'(cnt_reg);
                    wr_data_next = BLANK;
                    cnt_next     = cnt_reg + 1'b1;
                end else begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end

            IDLE: begin
                if (accept) begin
                    if (is_print) begin
                        wr_en_next   = 1'b1;
                        wr_addr_next = cursor_addr;
                        wr_data_next = {src.in_attr, src.in_data};
                        if (col_reg < LAST_COL) begin
                            col_next = col_reg + 7'd1;
                        end else begin
                            col_next      = '0;
                            row_next      = adv_row;
                            row_base_next = adv_base;
                            cnt_next      = '0;
                            state_next    = CLEAR_LINE;
                        end
                    end else if (src.in_data == CH_LF) begin
                        col_next      = '0;
                        row_next      = adv_row;
                        row_base_next = adv_base;
                        cnt_next      = '0;
                        state_next    = CLEAR_LINE;
                    end else if (src.in_data == CH_CR) begin
                        col_next = '0;
                    end else if (src.in_data == CH_BS) begin
                        if (col_reg != 7'd0) begin
                            col_next     = col_reg - 7'd1;
                            wr_en_next   = 1'b1;
                            wr_addr_next = cursor_addr - 1'b1;
                            wr_data_next = BLANK;
                        end
                    end else if (src.in_data == CH_FF) begin
                        col_next      = '0;
                        row_next      = '0;
                        row_base_next = '0;
                        cnt_next      = '0;
                        state_next    = CLEAR_ALL;
                    end
                end
            end

            default: begin
                state_next = CLEAR_ALL;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer: reset, full/line clears, printable writes,
// control codes, wrap-around and reset during a full clear.
module tb_text_writer;

    logic        clk_pix = 1'b0;
    logic        rst     = 1'b1;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    int checks = 0;
    int errors = 0;

    text_writer_if bus();

    text_writer #(
        .COLS(80), .ROWS(30), .ADDR_W(12), .ATTR_BLANK(8'h07)
    ) dut (
        .clk_pix    (clk_pix),
        .rst        (rst),
        .src        (bus),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clk_pix = ~clk_pix;

    // Offers one byte, waits (bounded) for acceptance and returns in the cycle after transfer.
    task automatic send_byte(input logic [7:0] d, input logic [7:0] a);
        int t = 0;
        while (bus.in_ready !== 1'b1 && t < 3000) begin
            @(negedge clk_pix);
            t++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b required 1 (byte %02h)", bus.in_ready, d);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_attr  = a;
        @(negedge clk_pix);
        bus.in_valid = 1'b0;
        $display("tx byte=%02h attr=%02h -> wr_en=%b addr=%0d data=%04h cursor=(%0d,%0d)",
                 d, a, wr_en, wr_addr, wr_data, cursor_col, cursor_row);
    endtask

    // Follows one clear sweep: n consecutive blank writes from base, then IDLE.
    task automatic check_burst(input int base, input int n, input string tag);
        int t = 0;
        int bad = 0;
        int bad_i = 0;
        logic [11:0] bad_addr;
        logic [15:0] bad_data;
        logic        bad_en;
        while (wr_en !== 1'b1 && t < 20) begin
            @(negedge clk_pix);
            t++;
        end
        checks++;
        if (wr_en !== 1'b1) begin
            errors++;
            $display("FAIL %s_start: wr_en=%b required 1", tag, wr_en);
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (wr_en !== 1'b1 || wr_addr !== 12'(base + i) || wr_data !== 16'h0720 ||
                busy !== 1'b1 || bus.in_ready !== 1'b0) begin
                if (bad == 0) begin
                    bad_i    = i;
                    bad_en   = wr_en;
                    bad_addr = wr_addr;
                    bad_data = wr_data;
                end
                bad++;
            end
            @(negedge clk_pix);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_sweep: %0d bad cycles, first i=%0d wr_en=%b addr=%0d data=%04h required wr_en=1 addr=%0d data=0720 busy=1 in_ready=0",
                     tag, bad, bad_i, bad_en, bad_addr, bad_data, base + bad_i);
        end
        checks++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_end: wr_en=%b busy=%b in_ready=%b required 0 0 1",
                     tag, wr_en, busy, bus.in_ready);
        end
        $display("burst %s base=%0d n=%0d bad=%0d", tag, base, n, bad);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_attr  = 8'h00;
        repeat (3) @(negedge clk_pix);
        checks++; if (wr_en !== 1'b0)         begin errors++; $display("FAIL reset_wr_en: got %b required 0", wr_en); end
        checks++; if (wr_addr !== 12'd0)      begin errors++; $display("FAIL reset_wr_addr: got %0d required 0", wr_addr); end
        checks++; if (wr_data !== 16'h0000)   begin errors++; $display("FAIL reset_wr_data: got %04h required 0000", wr_data); end
        checks++; if (cursor_col !== 7'd0 || cursor_row !== 5'd0)
                  begin errors++; $display("FAIL reset_cursor: got (%0d,%0d) required (0,0)", cursor_col, cursor_row); end
        checks++; if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready: got %b required 0", bus.in_ready); end
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        $display("reset held 3 cycles");
    endtask

    task automatic test_power_on_clear();
        rst = 1'b0;
        @(negedge clk_pix);
        checks++; if (busy !== 1'b1 || wr_en !== 1'b0)
                  begin errors++; $display("FAIL entry_cycle: busy=%b wr_en=%b required 1 0", busy, wr_en); end
        check_burst(0, 2400, "power_on");
    endtask

    task automatic test_printable();
        send_byte(8'h41, 8'h1F);
        checks++; if (wr_en !== 1'b1)         begin errors++; $display("FAIL print_wr_en: got %b required 1", wr_en); end
        checks++; if (wr_addr !== 12'd0)      begin errors++; $display("FAIL print_addr: got %0d required 0", wr_addr); end
        checks++; if (wr_data !== 16'h1F41)   begin errors++; $display("FAIL print_data: got %04h required 1F41", wr_data); end
        checks++; if (cursor_col !== 7'd1 || cursor_row !== 5'd0)
                  begin errors++; $display("FAIL print_cursor: got (%0d,%0d) required (1,0)", cursor_col, cursor_row); end
    endtask

    task automatic test_row_wrap();
        logic [7:0] ch;
        send_byte(8'h0D, 8'h00);
        checks++; if (wr_en !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'd0)
                  begin errors++; $display("FAIL cr: wr_en=%b cursor=(%0d,%0d) required 0 (0,0)", wr_en, cursor_col, cursor_row); end
        for (int i = 0; i < 80; i++) begin
            ch = 8'(8'h41 + (i % 26));
            send_byte(ch, 8'h2E);
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 12'(i) || wr_data !== {8'h2E, ch}) begin
                errors++;
                $display("FAIL row0_write%0d: wr_en=%b addr=%0d data=%04h required 1 %0d %04h",
                         i, wr_en, wr_addr, wr_data, i, {8'h2E, ch});
            end
        end
        checks++; if (cursor_col !== 7'd0 || cursor_row !== 5'd1)
                  begin errors++; $display("FAIL wrap_cursor: got (%0d,%0d) required (0,1)", cursor_col, cursor_row); end
        checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b1)
                  begin errors++; $display("FAIL wrap_busy: in_ready=%b busy=%b required 0 1", bus.in_ready, busy); end
        @(negedge clk_pix);
        check_burst(80, 80, "row1_clear");
    endtask

    task automatic test_lf_wrap();
        send_byte(8'h0C, 8'h00);
        checks++; if (wr_en !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'd0)
                  begin errors++; $display("FAIL ff: wr_en=%b cursor=(%0d,%0d) required 0 (0,0)", wr_en, cursor_col, cursor_row); end
        check_burst(0, 2400, "ff_clear");
        for (int r = 1; r < 30; r++) begin
            send_byte(8'h0A, 8'h00);
            checks++;
            if (wr_en !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'(r)) begin
                errors++;
                $display("FAIL lf%0d: wr_en=%b cursor=(%0d,%0d) required 0 (0,%0d)", r, wr_en, cursor_col, cursor_row, r);
            end
            check_burst(r * 80, 80, "lf_clear");
        end
        for (int i = 0; i < 5; i++) send_byte(8'h78, 8'h07);
        checks++; if (cursor_col !== 7'd5 || cursor_row !== 5'd29)
                  begin errors++; $display("FAIL pos_5_29: got (%0d,%0d) required (5,29)", cursor_col, cursor_row); end
        send_byte(8'h0A, 8'h00);
        checks++; if (wr_en !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'd0)
                  begin errors++; $display("FAIL lf_wrap: wr_en=%b cursor=(%0d,%0d) required 0 (0,0)", wr_en, cursor_col, cursor_row); end
        check_burst(0, 80, "wrap_clear");
    endtask

    task automatic test_backspace();
        send_byte(8'h0A, 8'h00);
        check_burst(80, 80, "bs_row1");
        send_byte(8'h0A, 8'h00);
        check_burst(160, 80, "bs_row2");
        for (int i = 0; i < 3; i++) send_byte(8'h61, 8'h07);
        send_byte(8'h08, 8'h00);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 12'd162 || wr_data !== 16'h0720)
                  begin errors++; $display("FAIL bs_write: wr_en=%b addr=%0d data=%04h required 1 162 0720", wr_en, wr_addr, wr_data); end
        checks++; if (cursor_col !== 7'd2 || cursor_row !== 5'd2)
                  begin errors++; $display("FAIL bs_cursor: got (%0d,%0d) required (2,2)", cursor_col, cursor_row); end
        send_byte(8'h0D, 8'h00);
        send_byte(8'h08, 8'h00);
        checks++; if (wr_en !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'd2)
                  begin errors++; $display("FAIL bs_col0: wr_en=%b cursor=(%0d,%0d) required 0 (0,2)", wr_en, cursor_col, cursor_row); end
        send_byte(8'h7F, 8'h00);
        checks++; if (wr_en !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'd2)
                  begin errors++; $display("FAIL del: wr_en=%b cursor=(%0d,%0d) required 0 (0,2)", wr_en, cursor_col, cursor_row); end
        send_byte(8'h51, 8'h4E);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 12'd160 || wr_data !== 16'h4E51)
                  begin errors++; $display("FAIL row2_write: wr_en=%b addr=%0d data=%04h required 1 160 4E51", wr_en, wr_addr, wr_data); end
        send_byte(8'h01, 8'h00);
        checks++; if (wr_en !== 1'b0 || cursor_col !== 7'd1 || cursor_row !== 5'd2)
                  begin errors++; $display("FAIL ctrl01: wr_en=%b cursor=(%0d,%0d) required 0 (1,2)", wr_en, cursor_col, cursor_row); end
    endtask

    task automatic test_reset_mid_clear();
        int t = 0;
        send_byte(8'h0C, 8'h00);
        while (!(wr_en === 1'b1 && wr_addr === 12'd1000) && t < 1200) begin
            @(negedge clk_pix);
            t++;
        end
        checks++; if (wr_addr !== 12'd1000)
                  begin errors++; $display("FAIL reach_1000: addr=%0d required 1000", wr_addr); end
        rst = 1'b1;
        @(negedge clk_pix);
        checks++; if (wr_en !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b0 || wr_addr !== 12'd0 || wr_data !== 16'h0000)
                  begin errors++; $display("FAIL mid_rst: wr_en=%b busy=%b in_ready=%b addr=%0d data=%04h required 0 0 0 0 0000",
                                           wr_en, busy, bus.in_ready, wr_addr, wr_data); end
        rst = 1'b0;
        $display("reset pulse during full clear");
        check_burst(0, 2400, "restart");
        checks++; if (cursor_col !== 7'd0 || cursor_row !== 5'd0)
                  begin errors++; $display("FAIL restart_cursor: got (%0d,%0d) required (0,0)", cursor_col, cursor_row); end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_attr  = 8'h00;
        test_reset();
        test_power_on_clear();
        test_printable();
        test_row_wrap();
        test_lf_wrap();
        test_backspace();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
